// File: rtl/sram_secded_pkg.sv
// Shared widths, codeword type and the SECDED encoder for the 256x8 memory test chip.
// Data bits sit at Hamming positions 3,5,6,7,9,10,11,12. Parity bits sit at 1,2,4,8.
package sram_secded_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CW_W   = 14;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [CW_W-1:0] cw_t;

    function automatic cw_t encode(input logic [DATA_W-1:0] d);
        cw_t cw;
        cw       = '0;
        cw[2]    = d[0];
        cw[6:4]  = d[3:1];
        cw[11:8] = d[7:4];
        cw[0]    = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        cw[1]    = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        cw[3]    = d[1] ^ d[2] ^ d[3] ^ d[7];
        cw[7]    = d[4] ^ d[5] ^ d[6] ^ d[7];
        cw[12]   = ^cw[11:0];
        cw[13]   = 1'b0;
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] extractData(input logic [CW_W-2:0] cw);
        return {cw[11:8], cw[6:4], cw[2]};
    endfunction

endpackage

// File: rtl/secded_dec_8.sv
// Combinational SECDED decoder over the 13 parity-covered codeword bits.
// The scrub marker (bit 13) is not an input because it is not covered by parity.
module secded_dec_8
    import sram_secded_pkg::*;
(
    input  logic [CW_W-2:0]   cw_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CW_W-2:0]   cw_o,
    output logic              single_err_o,
    output logic              double_err_o
);

    logic [3:0] syndrome;
    logic       parity;

    // A nonzero syndrome with odd overall parity points directly at the flipped bit.
    always_comb begin
        syndrome     = '0;
        parity       = ^cw_i;
        cw_o         = cw_i;
        single_err_o = 1'b0;
        double_err_o = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (cw_i[i]) begin
                syndrome = syndrome ^ 4'(i + 1);
            end
        end
        if (parity) begin
            if (syndrome == 4'd0) begin
                cw_o[12]     = ~cw_i[12];
                single_err_o = 1'b1;
            end else if (syndrome <= 4'd12) begin
                for (int i = 0; i < 12; i++) begin
                    if (syndrome == 4'(i + 1)) begin
                        cw_o[i] = ~cw_i[i];
                    end
                end
                single_err_o = 1'b1;
            end else begin
                double_err_o = 1'b1;
            end
        end else if (syndrome != 4'd0) begin
            double_err_o = 1'b1;
        end
        data_o = extractData(cw_o);
    end

endmodule

// File: rtl/sram_secded_256x8.sv
// 256x8 single-port SRAM model with SECDED protection and scrub-on-read.
// Corrected single-bit errors are written back with bit 13 set as a scrub marker.
module sram_secded_256x8
    import sram_secded_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    cw_t mem [0:DEPTH-1];

    logic [DATA_W-1:0] readData_q;
    logic [DATA_W-1:0] readData_d;
    logic [DATA_W-1:0] decData;
    logic [CW_W-2:0]   decCw;
    logic              singleErr;
    logic              doubleErr;
    logic              doRead;
    logic              doScrub;

    secded_dec_8 u_dec (
        .cw_i         (mem[addr][CW_W-2:0]),
        .data_o       (decData),
        .cw_o         (decCw),
        .single_err_o (singleErr),
        .double_err_o (doubleErr)
    );

    always_comb begin
        doRead     = enable && !we;
        doScrub    = doRead && singleErr && !doubleErr;
        readData_d = readData_q;
        if (doRead) begin
            readData_d = decData;
        end
    end

    // Reset clears every word to the all-zero codeword, which is the valid encoding of 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            readData_q <= '0;
        end else begin
            readData_q <= readData_d;
            if (enable && we) begin
                mem[addr] <= encode(data_in);
            end else if (doScrub) begin
                mem[addr] <= {1'b1, decCw};
            end
        end
    end

    assign data_out = readData_q;

endmodule

// File: tb/tb_sram_secded_256x8.sv
// Scoreboard bench for sram_secded_256x8: reads push expected data, results are popped
// one cycle later; error injection goes straight into the DUT array.
module tb_sram_secded_256x8;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       we;
    logic [7:0] addr;
    logic [7:0] dataIn;
    logic [7:0] dataOut;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] expQ [$];

    sram_secded_256x8 dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .we       (we),
        .addr     (addr),
        .data_in  (dataIn),
        .data_out (dataOut)
    );

    always #5 clk = ~clk;

    // Independent model: place data by position, then parity by position-bit membership.
    function automatic logic [13:0] modelEncode(input logic [7:0] d);
        int         pos [8];
        logic [12:0] c;
        logic        p;
        pos = '{3, 5, 6, 7, 9, 10, 11, 12};
        c   = '0;
        for (int j = 0; j < 8; j++) c[pos[j]-1] = d[j];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int j = 0; j < 8; j++) if ((pos[j] & (1 << k)) != 0) p = p ^ d[j];
            c[(1 << k) - 1] = p;
        end
        c[12] = ^c[11:0];
        return {1'b0, c};
    endfunction

    task automatic issueWrite(input logic [7:0] a, input logic [7:0] d);
        enable = 1'b1; we = 1'b1; addr = a; dataIn = d;
        @(posedge clk); #1;
        enable = 1'b0; we = 1'b0;
    endtask

    task automatic issueRead(input logic [7:0] a, input logic [7:0] exp);
        enable = 1'b1; we = 1'b0; addr = a;
        expQ.push_back(exp);
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        enable = 1'b0; we = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        logic [7:0] e;
        rst = 1'b1; enable = 1'b0; we = 1'b0; addr = '0; dataIn = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        vectors++;
        if (dataOut !== 8'h00) begin
            miscompares++; $display("[TB] FAIL reset_dout: got %h want 00", dataOut);
        end
        vectors++;
        if (dut.mem[255] !== 14'h0) begin
            miscompares++; $display("[TB] FAIL reset_mem255: got %h want 0000", dut.mem[255]);
        end
        issueRead(8'd42, 8'h00);
        e = expQ.pop_front(); vectors++;
        if (dataOut !== e) begin
            miscompares++; $display("[TB] FAIL read42_after_reset: got %h want %h", dataOut, e);
        end
        idleCycles(3);
        vectors++;
        if (dataOut !== 8'h00) begin
            miscompares++; $display("[TB] FAIL idle_hold_zero: got %h want 00", dataOut);
        end
    endtask

    task automatic test_write_read;
        logic [7:0] addrs [3];
        logic [7:0] datas [3];
        logic [7:0] e;
        addrs = '{8'd10, 8'd20, 8'd255};
        datas = '{8'h2C, 8'h3C, 8'hFF};
        for (int i = 0; i < 3; i++) issueWrite(addrs[i], datas[i]);
        vectors++;
        if (dataOut !== 8'h00) begin
            miscompares++; $display("[TB] FAIL write_hold: got %h want 00", dataOut);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dut.mem[addrs[i]] !== modelEncode(datas[i])) begin
                miscompares++;
                $display("[TB] FAIL encode_%0d: got %h want %h", addrs[i], dut.mem[addrs[i]], modelEncode(datas[i]));
            end
            issueRead(addrs[i], datas[i]);
            e = expQ.pop_front(); vectors++;
            if (dataOut !== e) begin
                miscompares++; $display("[TB] FAIL readback_%0d: got %h want %h", addrs[i], dataOut, e);
            end
        end
        idleCycles(2);
        issueWrite(8'd5, 8'h11);
        vectors++;
        if (dataOut !== 8'hFF) begin
            miscompares++; $display("[TB] FAIL hold_ff: got %h want ff", dataOut);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        issueWrite(8'd7, 8'h66);
        issueRead(8'd7, 8'h66);
        e = expQ.pop_front(); vectors++;
        if (dataOut !== e) begin
            miscompares++; $display("[TB] FAIL b2b_read: got %h want %h", dataOut, e);
        end
        issueRead(8'd5, 8'h11);
        e = expQ.pop_front(); vectors++;
        if (dataOut !== e) begin
            miscompares++; $display("[TB] FAIL b2b_read5: got %h want %h", dataOut, e);
        end
    endtask

    task automatic test_single_correct;
        logic [7:0]  e;
        logic [13:0] want;
        dut.mem[20] = dut.mem[20] ^ 14'h0010;
        issueRead(8'd20, 8'h3C);
        e = expQ.pop_front(); vectors++;
        if (dataOut !== e) begin
            miscompares++; $display("[TB] FAIL correct_data20: got %h want %h", dataOut, e);
        end
        want = modelEncode(8'h3C) | 14'h2000;
        vectors++;
        if (dut.mem[20] !== want) begin
            miscompares++; $display("[TB] FAIL scrub20: got %h want %h", dut.mem[20], want);
        end
        // Parity bit p8 flipped: data unaffected, codeword still restored.
        issueWrite(8'd50, 8'h91);
        dut.mem[50] = dut.mem[50] ^ 14'h0080;
        issueRead(8'd50, 8'h91);
        e = expQ.pop_front(); vectors++;
        if (dataOut !== e) begin
            miscompares++; $display("[TB] FAIL correct_data50: got %h want %h", dataOut, e);
        end
        want = modelEncode(8'h91) | 14'h2000;
        vectors++;
        if (dut.mem[50] !== want) begin
            miscompares++; $display("[TB] FAIL scrub50: got %h want %h", dut.mem[50], want);
        end
    endtask

    task automatic test_parity_fix;
        logic [7:0]  e;
        logic [13:0] want;
        issueWrite(8'd40, 8'h4C);
        dut.mem[40] = dut.mem[40] ^ 14'h1000;
        issueRead(8'd40, 8'h4C);
        e = expQ.pop_front(); vectors++;
        if (dataOut !== e) begin
            miscompares++; $display("[TB] FAIL overall_data40: got %h want %h", dataOut, e);
        end
        want = modelEncode(8'h4C) | 14'h2000;
        vectors++;
        if (dut.mem[40] !== want) begin
            miscompares++; $display("[TB] FAIL overall_scrub40: got %h want %h", dut.mem[40], want);
        end
    endtask

    task automatic test_double_detect;
        logic [7:0]  e;
        logic [13:0] corrupt;
        issueWrite(8'd30, 8'hA8);
        corrupt = modelEncode(8'hA8) ^ 14'h0024;
        dut.mem[30] = dut.mem[30] ^ 14'h0024;
        issueRead(8'd30, 8'hAD);
        e = expQ.pop_front(); vectors++;
        if (dataOut !== e) begin
            miscompares++; $display("[TB] FAIL double_data30: got %h want %h", dataOut, e);
        end
        vectors++;
        if (dut.mem[30] !== corrupt) begin
            miscompares++; $display("[TB] FAIL double_nowrite30: got %h want %h", dut.mem[30], corrupt);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] addrs [7];
        logic [7:0] e;
        addrs = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd255, 8'd77};
        rst = 1'b1; enable = 1'b1; we = 1'b1; addr = 8'd77; dataIn = 8'h5A;
        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b0; we = 1'b0;
        vectors++;
        if (dataOut !== 8'h00) begin
            miscompares++; $display("[TB] FAIL midreset_dout: got %h want 00", dataOut);
        end
        vectors++;
        if (dut.mem[77] !== 14'h0) begin
            miscompares++; $display("[TB] FAIL midreset_mem77: got %h want 0000", dut.mem[77]);
        end
        for (int i = 0; i < 7; i++) begin
            issueRead(addrs[i], 8'h00);
            e = expQ.pop_front(); vectors++;
            if (dataOut !== e) begin
                miscompares++; $display("[TB] FAIL midreset_read%0d: got %h want %h", addrs[i], dataOut, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; we = 1'b0; addr = '0; dataIn = '0;
        test_reset;
        test_write_read;
        test_back_to_back;
        test_single_correct;
        test_parity_fix;
        test_double_detect;
        test_reset_mid;
        if (expQ.size() != 0) begin
            miscompares++; $display("[TB] FAIL scoreboard_leftover: got %0d want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
